// File: rtl/ets_phase_sweeper.sv
// ---------------------------------------------------------------------------
// ets_phase_sweeper
//
// Equivalent-time-sampling sweep engine. Steps the MMCM fine phase shift one
// increment at a time through the PSEN/PSINCDEC/PSDONE handshake. At each
// phase point it waits a settle interval, counts comparator hits over a
// programmable number of samples, and writes that count into the capture
// buffer write port (w_addr/w_data/w_occur/w_ready).
//
// Ports:
//   S_AXI_ACLK     sole clock, also the MMCM PSCLK
//   S_AXI_ARESETN  synchronous reset, active-low
//   start          one-cycle start pulse, honoured only while idle
//   abort          level abort request
//   n_steps        points in the sweep (0 = 2^ADDR_WIDTH points)
//   n_avg          samples per point (0 is treated as 1)
//   dir            1 = increment phase, 0 = decrement phase
//   cmp_bit        comparator output, already synchronous to S_AXI_ACLK
//   ps_en          MMCM PSEN
//   ps_incdec      MMCM PSINCDEC
//   ps_done        MMCM PSDONE
//   w_addr         buffer write address (point index)
//   w_data         hit count, zero-extended
//   w_occur        buffer write request
//   w_ready        buffer accepts the write
//   busy           high whenever a sweep is in progress
//   done           one-cycle pulse on normal sweep completion
//   ps_err         sticky ps_done timeout flag, cleared by an accepted start
// ---------------------------------------------------------------------------
module ets_phase_sweeper #(
   parameter int ADDR_WIDTH    = 10,
   parameter int DATA_WIDTH    = 32,
   parameter int AVG_WIDTH     = 16,
   parameter int SETTLE_CYCLES = 8,
   parameter int PS_TIMEOUT    = 1024
) (
   input  logic                  S_AXI_ACLK,
   input  logic                  S_AXI_ARESETN,
   input  logic                  start,
   input  logic                  abort,
   input  logic [ADDR_WIDTH-1:0] n_steps,
   input  logic [AVG_WIDTH-1:0]  n_avg,
   input  logic                  dir,
   input  logic                  cmp_bit,
   output logic                  ps_en,
   output logic                  ps_incdec,
   input  logic                  ps_done,
   output logic [ADDR_WIDTH-1:0] w_addr,
   output logic [DATA_WIDTH-1:0] w_data,
   output logic                  w_occur,
   input  logic                  w_ready,
   output logic                  busy,
   output logic                  done,
   output logic                  ps_err
);

   // Hit counter has one extra bit so a full window of 2^AVG_WIDTH-1 hits
   // (or more) can never wrap.
   localparam int CNT_WIDTH = AVG_WIDTH + 1;

   // One shared interval timer serves settle, sample and timeout phases, so
   // it must hold the largest of the three terminal counts.
   localparam int TMAX_A      = (SETTLE_CYCLES > PS_TIMEOUT) ? SETTLE_CYCLES : PS_TIMEOUT;
   localparam int TMAX        = (TMAX_A > (1 << AVG_WIDTH)) ? TMAX_A : (1 << AVG_WIDTH);
   localparam int TIMER_WIDTH = $clog2(TMAX + 1);

   localparam logic [TIMER_WIDTH-1:0] SETTLE_LAST  = TIMER_WIDTH'(SETTLE_CYCLES - 1);
   localparam logic [TIMER_WIDTH-1:0] TIMEOUT_LAST = TIMER_WIDTH'(PS_TIMEOUT - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_SAMPLE,
      ST_WRITE,
      ST_SHIFT,
      ST_WAIT_DONE
   } state_t;

   state_t                 state_reg,      state_next;
   logic [TIMER_WIDTH-1:0] timer_reg,      timer_next;
   logic [ADDR_WIDTH-1:0]  idx_reg,        idx_next;
   logic [CNT_WIDTH-1:0]   hit_cnt_reg,    hit_cnt_next;
   logic [ADDR_WIDTH-1:0]  n_steps_reg,    n_steps_next;
   logic [AVG_WIDTH-1:0]   n_avg_reg,      n_avg_next;
   logic                   dir_reg,        dir_next;
   logic                   ps_err_reg,     ps_err_next;
   logic                   abort_pend_reg, abort_pend_next;
   logic                   done_reg,       done_next;

   // Index of the final point. n_steps = 0 wraps to all-ones, which makes a
   // zero request sweep the full 2^ADDR_WIDTH points with no special case.
   logic [ADDR_WIDTH-1:0]  last_idx;
   // Terminal timer value for the sample window; n_avg = 0 behaves as 1.
   logic [AVG_WIDTH-1:0]   avg_last;

   assign last_idx = n_steps_reg - ADDR_WIDTH'(1);
   assign avg_last = (n_avg_reg == '0) ? '0 : (n_avg_reg - AVG_WIDTH'(1));

   // ------------------------------------------------------------------
   // Outputs: all decoded from registered state only.
   // ------------------------------------------------------------------
   assign ps_en     = (state_reg == ST_SHIFT);
   assign ps_incdec = ps_en & dir_reg;
   assign w_occur   = (state_reg == ST_WRITE);
   assign w_addr    = idx_reg;
   assign w_data    = DATA_WIDTH'(hit_cnt_reg);
   assign busy      = (state_reg != ST_IDLE);
   assign done      = done_reg;
   assign ps_err    = ps_err_reg;

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) begin
         state_reg      <= ST_IDLE;
         timer_reg      <= '0;
         idx_reg        <= '0;
         hit_cnt_reg    <= '0;
         n_steps_reg    <= '0;
         n_avg_reg      <= '0;
         dir_reg        <= 1'b0;
         ps_err_reg     <= 1'b0;
         abort_pend_reg <= 1'b0;
         done_reg       <= 1'b0;
      end else begin
         state_reg      <= state_next;
         timer_reg      <= timer_next;
         idx_reg        <= idx_next;
         hit_cnt_reg    <= hit_cnt_next;
         n_steps_reg    <= n_steps_next;
         n_avg_reg      <= n_avg_next;
         dir_reg        <= dir_next;
         ps_err_reg     <= ps_err_next;
         abort_pend_reg <= abort_pend_next;
         done_reg       <= done_next;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_next      = state_reg;
      timer_next      = timer_reg;
      idx_next        = idx_reg;
      hit_cnt_next    = hit_cnt_reg;
      n_steps_next    = n_steps_reg;
      n_avg_next      = n_avg_reg;
      dir_next        = dir_reg;
      ps_err_next     = ps_err_reg;
      abort_pend_next = abort_pend_reg;
      done_next       = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            abort_pend_next = 1'b0;
            timer_next      = '0;
            // abort takes priority over a coincident start
            if (start && !abort) begin
               n_steps_next = n_steps;
               n_avg_next   = n_avg;
               dir_next     = dir;
               idx_next     = '0;
               hit_cnt_next = '0;
               ps_err_next  = 1'b0;
               state_next   = ST_SETTLE;
            end
         end

         ST_SETTLE: begin
            if (abort) begin
               timer_next = '0;
               state_next = ST_IDLE;
            end else if (timer_reg == SETTLE_LAST) begin
               timer_next = '0;
               state_next = ST_SAMPLE;
            end else begin
               timer_next = timer_reg + TIMER_WIDTH'(1);
            end
         end

         ST_SAMPLE: begin
            if (abort) begin
               timer_next = '0;
               state_next = ST_IDLE;
            end else begin
               // The last sample cycle also accumulates, so the count is
               // complete on entry to WRITE.
               hit_cnt_next = hit_cnt_reg + CNT_WIDTH'(cmp_bit);
               if (timer_reg == TIMER_WIDTH'(avg_last)) begin
                  timer_next = '0;
                  state_next = ST_WRITE;
               end else begin
                  timer_next = timer_reg + TIMER_WIDTH'(1);
               end
            end
         end

         ST_WRITE: begin
            if (w_ready) begin
               // Write completes on this edge even if abort is also high;
               // abort only suppresses done and further points.
               hit_cnt_next = '0;
               if (abort) begin
                  state_next = ST_IDLE;
               end else if (idx_reg == last_idx) begin
                  state_next = ST_IDLE;
                  done_next  = 1'b1;
               end else begin
                  idx_next   = idx_reg + ADDR_WIDTH'(1);
                  state_next = ST_SHIFT;
               end
            end else if (abort) begin
               // Pending write is dropped.
               hit_cnt_next = '0;
               state_next   = ST_IDLE;
            end
         end

         ST_SHIFT: begin
            // Abort cannot interrupt the MMCM handshake; remember it and
            // act once PSDONE (or the timeout) arrives.
            if (abort) begin
               abort_pend_next = 1'b1;
            end
            timer_next = '0;
            state_next = ST_WAIT_DONE;
         end

         ST_WAIT_DONE: begin
            if (ps_done) begin
               timer_next      = '0;
               abort_pend_next = 1'b0;
               state_next      = (abort_pend_reg || abort) ? ST_IDLE : ST_SETTLE;
            end else if (timer_reg == TIMEOUT_LAST) begin
               timer_next      = '0;
               abort_pend_next = 1'b0;
               ps_err_next     = 1'b1;
               state_next      = ST_IDLE;
            end else begin
               timer_next = timer_reg + TIMER_WIDTH'(1);
               if (abort) begin
                  abort_pend_next = 1'b1;
               end
            end
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_ets_phase_sweeper.sv
// ---------------------------------------------------------------------------
// tb_ets_phase_sweeper
//
// Self-checking bench for ets_phase_sweeper. Sweeps are driven with random
// comparator data, random w_ready back-pressure, random PSDONE latency and
// random spurious start/ps_done activity; a timeline model derived from the
// settle/sample/handshake rules predicts when each write, phase step and
// done pulse must appear and what count each write must carry. Directed
// tasks cover timeout, abort, simultaneous-event and reset cases.
// ---------------------------------------------------------------------------
module tb_ets_phase_sweeper;

   localparam int AW  = 4;
   localparam int DW  = 16;
   localparam int VW  = 6;
   localparam int SET = 3;
   localparam int PTO = 40;

   logic          clk = 1'b0;
   logic          aresetn;
   logic          start;
   logic          abort;
   logic [AW-1:0] n_steps;
   logic [VW-1:0] n_avg;
   logic          dir;
   logic          cmp_bit;
   logic          ps_en;
   logic          ps_incdec;
   logic          ps_done;
   logic [AW-1:0] w_addr;
   logic [DW-1:0] w_data;
   logic          w_occur;
   logic          w_ready;
   logic          busy;
   logic          done;
   logic          ps_err;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ets_phase_sweeper #(
      .ADDR_WIDTH    (AW),
      .DATA_WIDTH    (DW),
      .AVG_WIDTH     (VW),
      .SETTLE_CYCLES (SET),
      .PS_TIMEOUT    (PTO)
   ) dut (
      .S_AXI_ACLK    (clk),
      .S_AXI_ARESETN (aresetn),
      .start         (start),
      .abort         (abort),
      .n_steps       (n_steps),
      .n_avg         (n_avg),
      .dir           (dir),
      .cmp_bit       (cmp_bit),
      .ps_en         (ps_en),
      .ps_incdec     (ps_incdec),
      .ps_done       (ps_done),
      .w_addr        (w_addr),
      .w_data        (w_data),
      .w_occur       (w_occur),
      .w_ready       (w_ready),
      .busy          (busy),
      .done          (done),
      .ps_err        (ps_err)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got running required finished");
      $fatal(1);
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d required %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive_quiet();
      start   = 1'b0;
      abort   = 1'b0;
      ps_done = 1'b0;
      w_ready = 1'b0;
      cmp_bit = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_ps_en"},     32'(ps_en),     0);
      check_val({tag, "_ps_incdec"}, 32'(ps_incdec), 0);
      check_val({tag, "_w_addr"},    32'(w_addr),    0);
      check_val({tag, "_w_data"},    32'(w_data),    0);
      check_val({tag, "_w_occur"},   32'(w_occur),   0);
      check_val({tag, "_busy"},      32'(busy),      0);
      check_val({tag, "_done"},      32'(done),      0);
      check_val({tag, "_ps_err"},    32'(ps_err),    0);
   endtask

   // Comparator pattern: 0 random, 1 always high, 2 toggling by edge number.
   function automatic bit gen_cmp(input int mode, input int e);
      if (mode == 1) return 1'b1;
      if (mode == 2) return (e % 2) != 0;
      return 1'($urandom_range(1));
   endfunction

   // One complete sweep against the timeline model. Edge 1 is the start
   // edge; every observation happens at the negedge after edge r.
   task automatic run_sweep(input int steps, input int avg, input bit d, input int cmp_mode,
                            input int ready_pct, input int hold0, input int lat_fix);
      int pts, a, k, t_set, wr_start, acc_edge, pd_edge, fin_edge, r, exp_sum;
      bit in_shift, finished, exp_wo, exp_pe, exp_dn, exp_bz;
      bit cmp_hist [0:8191];
      pts      = (steps == 0) ? (1 << AW) : steps;
      a        = (avg == 0) ? 1 : avg;
      k        = 0;
      t_set    = 1;
      wr_start = 1 + SET + a;
      acc_edge = -1;
      pd_edge  = -1;
      fin_edge = -1;
      r        = 0;
      in_shift = 1'b0;
      finished = 1'b0;
      start    = 1'b1;
      n_steps  = AW'(steps);
      n_avg    = VW'(avg);
      dir      = d;
      abort    = 1'b0;
      ps_done  = 1'b0;
      w_ready  = 1'b0;
      cmp_bit  = gen_cmp(cmp_mode, 1);
      cmp_hist[1] = cmp_bit;
      while (!finished || r < fin_edge + 3) begin
         if (r > 6000) begin
            check_val("sweep_timeout_points", k, pts);
            break;
         end
         @(posedge clk);
         r++;
         @(negedge clk);
         // model events that happened at edge r
         if (!in_shift && !finished && r == acc_edge) begin
            if (k == pts - 1) begin
               finished = 1'b1;
               fin_edge = r;
            end else begin
               in_shift = 1'b1;
               pd_edge  = r + ((lat_fix > 0) ? lat_fix : int'($urandom_range(2, 7)));
            end
         end else if (in_shift && r == pd_edge) begin
            in_shift = 1'b0;
            k++;
            t_set    = r;
            wr_start = r + SET + a;
            acc_edge = -1;
         end
         exp_wo = !finished && !in_shift && (r >= wr_start);
         exp_pe = in_shift && (r == acc_edge);
         exp_dn = finished && (r == fin_edge);
         exp_bz = !finished;
         check_val("sweep_ps_en",   32'(ps_en),   32'(exp_pe));
         check_val("sweep_w_occur", 32'(w_occur), 32'(exp_wo));
         check_val("sweep_done",    32'(done),    32'(exp_dn));
         check_val("sweep_busy",    32'(busy),    32'(exp_bz));
         check_val("sweep_ps_err",  32'(ps_err),  0);
         if (exp_pe) check_val("sweep_ps_incdec", 32'(ps_incdec), 32'(d));
         if (exp_wo) begin
            exp_sum = 0;
            for (int e = t_set + SET + 1; e <= t_set + SET + a; e++) exp_sum += int'(cmp_hist[e]);
            check_val("sweep_w_addr", 32'(w_addr), k % (1 << AW));
            check_val("sweep_w_data", 32'(w_data), exp_sum);
         end
         // drive inputs for edge r+1
         start   = !finished && ($urandom_range(15) == 0);
         n_steps = AW'($urandom);
         n_avg   = VW'($urandom);
         dir     = 1'($urandom);
         cmp_bit = gen_cmp(cmp_mode, r + 1);
         if (r + 1 < 8192) cmp_hist[r + 1] = cmp_bit;
         if (in_shift)
            ps_done = (r + 1 == pd_edge) || ((r + 1 == acc_edge + 1) && ($urandom_range(1) == 1));
         else
            ps_done = ($urandom_range(7) == 0);
         if (exp_wo) begin
            w_ready = (k == 0 && r < wr_start + hold0) ? 1'b0 : ($urandom_range(99) < ready_pct);
            if (w_ready) acc_edge = r + 1;
         end else begin
            w_ready = 1'($urandom);
         end
      end
      drive_quiet();
      tick();
   endtask

   // PSDONE never returns: ps_err must rise exactly PTO cycles after
   // WAIT_DONE is entered, with no done pulse; a later start clears it.
   task automatic test_timeout();
      int pe;
      drive_quiet();
      start   = 1'b1;
      n_steps = AW'(2);
      n_avg   = VW'(1);
      dir     = 1'b1;
      w_ready = 1'b1;
      cmp_bit = 1'b1;
      tick();
      start = 1'b0;
      pe = SET + 3;  // write visible after SET+2, accepted at SET+3
      for (int r = 1; r <= pe + PTO + 3; r++) begin
         check_val("to_ps_en", 32'(ps_en), 32'(r == pe));
         if (r == pe) check_val("to_ps_incdec", 32'(ps_incdec), 1);
         check_val("to_ps_err", 32'(ps_err), 32'(r >= pe + 1 + PTO));
         check_val("to_busy",   32'(busy),   32'(r < pe + 1 + PTO));
         check_val("to_done",   32'(done),   0);
         tick();
      end
      start   = 1'b1;
      n_steps = AW'(1);
      tick();
      start = 1'b0;
      check_val("to_clear_ps_err", 32'(ps_err), 0);
      check_val("to_restart_busy", 32'(busy),   1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check_val("to_abort_busy", 32'(busy), 0);
      drive_quiet();
      tick();
   endtask

   // Abort in SAMPLE: idle next cycle, the point is never written.
   task automatic test_abort_sample();
      drive_quiet();
      start   = 1'b1;
      n_steps = AW'(2);
      n_avg   = VW'(10);
      dir     = 1'b1;
      w_ready = 1'b1;
      tick();
      start = 1'b0;
      for (int r = 1; r <= SET + 20; r++) begin
         check_val("abs_busy",    32'(busy),    32'(r < SET + 4));
         check_val("abs_w_occur", 32'(w_occur), 0);
         check_val("abs_ps_en",   32'(ps_en),   0);
         check_val("abs_done",    32'(done),    0);
         abort = (r == SET + 3);
         tick();
      end
      drive_quiet();
   endtask

   // Abort during WAIT_DONE: stays until PSDONE, then idle, no more steps.
   task automatic test_abort_wait();
      int pe;
      drive_quiet();
      start   = 1'b1;
      n_steps = AW'(3);
      n_avg   = VW'(1);
      dir     = 1'b0;
      w_ready = 1'b1;
      tick();
      start = 1'b0;
      pe = SET + 3;
      for (int r = 1; r <= pe + 30; r++) begin
         check_val("abw_busy",    32'(busy),    32'(r < pe + 6));
         check_val("abw_ps_en",   32'(ps_en),   32'(r == pe));
         check_val("abw_w_occur", 32'(w_occur), 32'(r == SET + 2));
         check_val("abw_done",    32'(done),    0);
         if (r == pe) check_val("abw_ps_incdec", 32'(ps_incdec), 0);
         abort   = (r == pe + 1);
         ps_done = (r + 1 == pe + 6);
         tick();
      end
      drive_quiet();
   endtask

   // abort+start in idle, and w_ready+abort together in WRITE.
   task automatic test_simultaneous();
      drive_quiet();
      start   = 1'b1;
      abort   = 1'b1;
      n_steps = AW'(2);
      n_avg   = VW'(1);
      tick();
      drive_quiet();
      check_val("sim_abort_start_busy", 32'(busy), 0);
      tick();
      check_val("sim_abort_start_busy2", 32'(busy), 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int r = 1; r <= SET + 10; r++) begin
         check_val("sim_wr_w_occur", 32'(w_occur), 32'(r == SET + 2));
         check_val("sim_wr_busy",    32'(busy),    32'(r < SET + 3));
         check_val("sim_wr_done",    32'(done),    0);
         check_val("sim_wr_ps_en",   32'(ps_en),   0);
         w_ready = (r == SET + 2);
         abort   = (r == SET + 2);
         tick();
      end
      drive_quiet();
   endtask

   // Reset asserted while a write is pending.
   task automatic test_reset_in_write();
      drive_quiet();
      start   = 1'b1;
      n_steps = AW'(2);
      n_avg   = VW'(3);
      dir     = 1'b1;
      cmp_bit = 1'b1;
      tick();
      start = 1'b0;
      repeat (SET + 3) tick();
      check_val("rst_pre_w_occur", 32'(w_occur), 1);
      check_val("rst_pre_w_data",  32'(w_data),  3);
      aresetn = 1'b0;
      tick();
      check_all_zero("rst_in_write");
      aresetn = 1'b1;
      drive_quiet();
      tick();
   endtask

   initial begin
      aresetn = 1'b0;
      n_steps = '0;
      n_avg   = '0;
      dir     = 1'b0;
      drive_quiet();
      tick();
      check_all_zero("reset");
      tick();
      aresetn = 1'b1;
      tick();
      check_all_zero("post_reset_idle");

      run_sweep(4, 10, 1'b1, 1, 100, 0, 3);
      run_sweep(3, 0, 1'b1, 2, 100, 0, 0);
      run_sweep(1, 0, 1'b1, 2, 100, 0, 0);
      run_sweep(2, 5, 1'b1, 0, 100, 20, 0);
      test_timeout();
      test_abort_sample();
      test_abort_wait();
      test_simultaneous();
      test_reset_in_write();
      run_sweep(3, 4, 1'b0, 0, 60, 0, 0);
      run_sweep(0, 2, 1'b1, 0, 70, 0, 0);
      for (int i = 0; i < 10; i++) begin
         run_sweep(int'($urandom_range(0, 5)), int'($urandom_range(0, 12)), 1'($urandom),
                   0, int'($urandom_range(30, 100)), 0, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
